// File: rtl/vc_tagged_pipe_reg_pkg.sv
// Shared definitions for the tagged elastic pipeline register.
// A domain tag is one bit, and the low domain is also the scrub value.
package vc_tagged_pipe_reg_pkg;

    localparam logic DOM_L = 1'b0;
    localparam logic DOM_H = 1'b1;

endpackage

// File: rtl/vc_tagged_stage.sv
// One pipeline entry (valid, payload, domain tag).
// An entry that is vacated and not refilled is scrubbed back to the reset payload and the low domain.
module vc_tagged_stage
    import vc_tagged_pipe_reg_pkg::*;
#(
    parameter int                 p_nbits       = 32,
    parameter logic [p_nbits-1:0] p_reset_value = '0
)(
    input  logic               clk,
    input  logic               i_clr,
    input  logic               i_load,
    input  logic               i_unload,
    input  logic [p_nbits-1:0] i_msg,
    input  logic               i_dom,
    output logic               o_val,
    output logic [p_nbits-1:0] o_msg,
    output logic               o_dom
);

    logic               r_val;
    logic [p_nbits-1:0] r_msg;
    logic               r_dom;

    // A refill wins over the scrub, so a stage that passes its item on while taking a new one never shows the scrub value.
    always_ff @(posedge clk) begin
        if (i_clr) begin
            r_val <= 1'b0;
            r_msg <= p_reset_value;
            r_dom <= DOM_L;
        end else if (i_load) begin
            r_val <= 1'b1;
            r_msg <= i_msg;
            r_dom <= i_dom;
        end else if (i_unload) begin
            r_val <= 1'b0;
            r_msg <= p_reset_value;
            r_dom <= DOM_L;
        end
    end

    assign o_val = r_val;
    assign o_msg = r_msg;
    assign o_dom = r_dom;

endmodule

// File: rtl/vc_tagged_pipe_reg.sv
// Elastic multi-stage pipeline register with a per-entry security-domain tag, flush and occupancy count.
// Stage 0 is on the input side and stage p_nstages-1 drives the output.
module vc_tagged_pipe_reg
    import vc_tagged_pipe_reg_pkg::*;
#(
    parameter int                 p_nbits       = 32,
    parameter int                 p_nstages     = 2,
    parameter logic [p_nbits-1:0] p_reset_value = '0,
    parameter int                 p_cnt_nbits   = $clog2(p_nstages+1)
)(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   in_val,
    output logic                   in_rdy,
    input  logic [p_nbits-1:0]     in_msg,
    input  logic                   in_domain,
    output logic                   out_val,
    input  logic                   out_rdy,
    output logic [p_nbits-1:0]     out_msg,
    output logic                   out_domain,
    output logic [p_cnt_nbits-1:0] count
);

    logic                   w_clr;
    logic                   w_in_xfer;
    logic                   w_out_xfer;
    logic [p_nstages-1:0]   w_val;
    logic [p_nstages-1:0]   w_dom;
    logic [p_nstages-1:0]   w_move;
    logic [p_nstages-1:0]   w_load;
    logic [p_nbits-1:0]     w_msg [p_nstages];
    logic [p_cnt_nbits-1:0] r_count;

    assign w_clr = reset | flush;

    // Ready ripples back from the output, so a full pipe still accepts when its head leaves this cycle.
    always_comb begin
        w_move = '0;
        w_move[p_nstages-1] = w_val[p_nstages-1] && out_rdy;
        for (int i = p_nstages - 2; i >= 0; i--) begin
            w_move[i] = w_val[i] && (!w_val[i+1] || w_move[i+1]);
        end
    end

    assign in_rdy     = !w_clr && (!w_val[0] || w_move[0]);
    assign out_val    = !w_clr && w_val[p_nstages-1];
    assign w_in_xfer  = in_val && in_rdy;
    assign w_out_xfer = out_val && out_rdy;

    for (genvar gi = 0; gi < p_nstages; gi++) begin : g_stage
        logic [p_nbits-1:0] w_ld_msg;
        logic               w_ld_dom;

        if (gi == 0) begin : g_head
            assign w_load[gi] = w_in_xfer;
            assign w_ld_msg   = in_msg;
            assign w_ld_dom   = in_domain;
        end else begin : g_link
            assign w_load[gi] = w_move[gi-1];
            assign w_ld_msg   = w_msg[gi-1];
            assign w_ld_dom   = w_dom[gi-1];
        end

        vc_tagged_stage #(
            .p_nbits       (p_nbits),
            .p_reset_value (p_reset_value)
        ) u_stage (
            .clk      (clk),
            .i_clr    (w_clr),
            .i_load   (w_load[gi]),
            .i_unload (w_move[gi]),
            .i_msg    (w_ld_msg),
            .i_dom    (w_ld_dom),
            .o_val    (w_val[gi]),
            .o_msg    (w_msg[gi]),
            .o_dom    (w_dom[gi])
        );
    end

    assign out_msg    = out_val ? w_msg[p_nstages-1] : p_reset_value;
    assign out_domain = out_val ? w_dom[p_nstages-1] : DOM_L;

    // Both transfers are forced low during reset/flush, so the clear branch alone sets the count then.
    always_ff @(posedge clk) begin
        if (w_clr) begin
            r_count <= '0;
        end else if (w_in_xfer && !w_out_xfer) begin
            r_count <= r_count + p_cnt_nbits'(1);
        end else if (w_out_xfer && !w_in_xfer) begin
            r_count <= r_count - p_cnt_nbits'(1);
        end
    end

    assign count = r_count;

    a_ctrl_known: assert property (@(posedge clk) disable iff (reset)
        !$isunknown({in_val, out_rdy, flush}));

endmodule

// File: tb/tb_vc_tagged_pipe_reg.sv
// Directed bench for vc_tagged_pipe_reg with 8-bit payload, 3 stages and reset value 0.
// Each table row holds one cycle's inputs and the outputs expected before that cycle's clock edge.
module tb_vc_tagged_pipe_reg;
    import vc_tagged_pipe_reg_pkg::*;

    localparam logic T = 1'b1;
    localparam logic F = 1'b0;
    localparam int   NV = 27;

    typedef struct {
        logic       rst;
        logic       fl;
        logic       iv;
        logic [7:0] im;
        logic       id;
        logic       ordy;
        logic       e_rdy;
        logic       e_ov;
        logic [7:0] e_om;
        logic       e_od;
        logic [1:0] e_cnt;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset, flush, in_val, in_rdy, in_domain;
    logic       out_val, out_rdy, out_domain;
    logic [7:0] in_msg, out_msg;
    logic [1:0] count;

    int   n_checks = 0;
    int   n_errors = 0;
    vec_t tbl [NV];

    always #5 clk = ~clk;

    vc_tagged_pipe_reg #(
        .p_nbits       (8),
        .p_nstages     (3),
        .p_reset_value (8'h00)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .in_val     (in_val),
        .in_rdy     (in_rdy),
        .in_msg     (in_msg),
        .in_domain  (in_domain),
        .out_val    (out_val),
        .out_rdy    (out_rdy),
        .out_msg    (out_msg),
        .out_domain (out_domain),
        .count      (count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // {val, dom, msg} of one internal stage
    function automatic logic [9:0] stage_word(input int i);
        case (i)
            0:       return {dut.g_stage[0].u_stage.r_val, dut.g_stage[0].u_stage.r_dom, dut.g_stage[0].u_stage.r_msg};
            1:       return {dut.g_stage[1].u_stage.r_val, dut.g_stage[1].u_stage.r_dom, dut.g_stage[1].u_stage.r_msg};
            default: return {dut.g_stage[2].u_stage.r_val, dut.g_stage[2].u_stage.r_dom, dut.g_stage[2].u_stage.r_msg};
        endcase
    endfunction

    task automatic drive(input logic rst, input logic fl, input logic iv, input logic [7:0] im,
                         input logic id, input logic ordy);
        reset = rst; flush = fl; in_val = iv; in_msg = im; in_domain = id; out_rdy = ordy;
    endtask

    initial begin
        //          rst fl iv  im     id     ordy | rdy ov  om     od     cnt
        // reset, second cycle; first cycle is checked by hand below
        tbl[0]  = '{T, F, T, 8'h55, DOM_H, F,  F, F, 8'h00, DOM_L, 2'd0};
        tbl[1]  = '{F, F, F, 8'h00, DOM_L, T,  T, F, 8'h00, DOM_L, 2'd0};
        // streaming 11/L 22/H 33/L, outputs three cycles later
        tbl[2]  = '{F, F, T, 8'h11, DOM_L, T,  T, F, 8'h00, DOM_L, 2'd0};
        tbl[3]  = '{F, F, T, 8'h22, DOM_H, T,  T, F, 8'h00, DOM_L, 2'd1};
        tbl[4]  = '{F, F, T, 8'h33, DOM_L, T,  T, F, 8'h00, DOM_L, 2'd2};
        tbl[5]  = '{F, F, F, 8'h00, DOM_L, T,  T, T, 8'h11, DOM_L, 2'd3};
        tbl[6]  = '{F, F, F, 8'h00, DOM_L, T,  T, T, 8'h22, DOM_H, 2'd2};
        tbl[7]  = '{F, F, F, 8'h00, DOM_L, T,  T, T, 8'h33, DOM_L, 2'd1};
        tbl[8]  = '{F, F, F, 8'h00, DOM_L, T,  T, F, 8'h00, DOM_L, 2'd0};
        // backpressure: four offered, three taken, then in/out together at full
        tbl[9]  = '{F, F, T, 8'hA1, DOM_H, F,  T, F, 8'h00, DOM_L, 2'd0};
        tbl[10] = '{F, F, T, 8'hA2, DOM_L, F,  T, F, 8'h00, DOM_L, 2'd1};
        tbl[11] = '{F, F, T, 8'hA3, DOM_H, F,  T, F, 8'h00, DOM_L, 2'd2};
        tbl[12] = '{F, F, T, 8'hA4, DOM_L, F,  F, T, 8'hA1, DOM_H, 2'd3};
        tbl[13] = '{F, F, T, 8'hA4, DOM_L, T,  T, T, 8'hA1, DOM_H, 2'd3};
        tbl[14] = '{F, F, F, 8'h00, DOM_L, T,  T, T, 8'hA2, DOM_L, 2'd3};
        tbl[15] = '{F, F, F, 8'h00, DOM_L, T,  T, T, 8'hA3, DOM_H, 2'd2};
        tbl[16] = '{F, F, F, 8'h00, DOM_L, T,  T, T, 8'hA4, DOM_L, 2'd1};
        tbl[17] = '{F, F, F, 8'h00, DOM_L, T,  T, F, 8'h00, DOM_L, 2'd0};
        // flush with two H entries; B3 offered during flush must be dropped
        tbl[18] = '{F, F, T, 8'hB1, DOM_H, F,  T, F, 8'h00, DOM_L, 2'd0};
        tbl[19] = '{F, F, T, 8'hB2, DOM_H, F,  T, F, 8'h00, DOM_L, 2'd1};
        tbl[20] = '{F, T, T, 8'hB3, DOM_L, T,  F, F, 8'h00, DOM_L, 2'd2};
        tbl[21] = '{F, F, F, 8'h00, DOM_L, T,  T, F, 8'h00, DOM_L, 2'd0};
        // reset while two entries (head valid) and out_rdy=1
        tbl[22] = '{F, F, T, 8'hC1, DOM_L, F,  T, F, 8'h00, DOM_L, 2'd0};
        tbl[23] = '{F, F, T, 8'hC2, DOM_H, F,  T, F, 8'h00, DOM_L, 2'd1};
        tbl[24] = '{F, F, F, 8'h00, DOM_L, F,  T, F, 8'h00, DOM_L, 2'd2};
        tbl[25] = '{T, F, T, 8'hC3, DOM_H, T,  F, F, 8'h00, DOM_L, 2'd2};
        tbl[26] = '{F, F, F, 8'h00, DOM_L, T,  T, F, 8'h00, DOM_L, 2'd0};

        // first reset cycle: count still undefined, outputs must already be gated
        @(negedge clk);
        drive(T, F, T, 8'h55, DOM_H, F);
        #2;
        chk("rst0 in_rdy",  {31'd0, in_rdy},  32'd0);
        chk("rst0 out_val", {31'd0, out_val}, 32'd0);
        chk("rst0 out_msg", {24'd0, out_msg}, 32'h00);

        for (int k = 0; k < NV; k++) begin
            @(negedge clk);
            drive(tbl[k].rst, tbl[k].fl, tbl[k].iv, tbl[k].im, tbl[k].id, tbl[k].ordy);
            #2;
            chk($sformatf("row%0d in_rdy", k),     {31'd0, in_rdy},     {31'd0, tbl[k].e_rdy});
            chk($sformatf("row%0d out_val", k),    {31'd0, out_val},    {31'd0, tbl[k].e_ov});
            chk($sformatf("row%0d out_msg", k),    {24'd0, out_msg},    {24'd0, tbl[k].e_om});
            chk($sformatf("row%0d out_domain", k), {31'd0, out_domain}, {31'd0, tbl[k].e_od});
            chk($sformatf("row%0d count", k),      {30'd0, count},      {30'd0, tbl[k].e_cnt});
        end

        // flush and mid-stream reset both left every stage scrubbed
        for (int i = 0; i < 3; i++)
            chk($sformatf("cleared stage%0d", i), {22'd0, stage_word(i)}, 32'd0);

        // scrub: walk AA/H through the pipe and watch each vacated stage
        @(negedge clk);
        drive(F, F, T, 8'hAA, DOM_H, T);
        #2;
        chk("scrub accept", {31'd0, in_rdy}, 32'd1);
        @(negedge clk);
        drive(F, F, F, 8'h00, DOM_L, T);
        #2;
        chk("scrub s0 loaded", {22'd0, stage_word(0)}, {22'd0, 2'b11, 8'hAA});
        @(negedge clk);
        chk("scrub s0 vacated", {22'd0, stage_word(0)}, 32'd0);
        chk("scrub s1 loaded",  {22'd0, stage_word(1)}, {22'd0, 2'b11, 8'hAA});
        @(negedge clk);
        chk("scrub s1 vacated", {22'd0, stage_word(1)}, 32'd0);
        chk("scrub out_val",    {31'd0, out_val},       32'd1);
        chk("scrub out_msg",    {24'd0, out_msg},       32'hAA);
        chk("scrub out_domain", {31'd0, out_domain},    32'd1);
        @(negedge clk);
        chk("scrub s2 vacated",   {22'd0, stage_word(2)}, 32'd0);
        chk("scrub empty val",    {31'd0, out_val},       32'd0);
        chk("scrub empty msg",    {24'd0, out_msg},       32'h00);
        chk("scrub empty domain", {31'd0, out_domain},    32'd0);
        chk("scrub empty count",  {30'd0, count},         32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
